// File: rtl/ysyx_25060170_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_ifu -- instruction fetch stage
//
// Holds the PC, issues one instruction-memory word fetch at a time and hands
// {inst, pc} to decode over a valid/ready handshake.  A redirect from execute
// replaces the PC and discards whatever fetch result is in flight or held.
//
// Ports
//   clk             in   system clock, all state on rising edge
//   rst             in   asynchronous active-low reset (0 = reset)
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_addr       out  fetch address (word aligned, equals current PC)
//   imem_rsp_valid  in   response valid, one cycle per accepted request
//   imem_rsp_data   in   fetched instruction word
//   redirect_i      in   one-cycle pulse: replace PC with redirect_pc_i
//   redirect_pc_i   in   redirect target, low two bits ignored
//   inst_valid_o    out  inst_o / inst_addr_o valid toward decode
//   inst_ready_i    in   decode accepts the instruction
//   inst_o          out  instruction word toward decode
//   inst_addr_o     out  PC of inst_o
// ---------------------------------------------------------------------------
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;        // outstanding response belongs to a squashed PC
  logic            r_req_valid;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_addr;

  logic [XLEN-1:0] w_redirect_pc;
  logic            w_drop_rsp;

  // Force word alignment of the redirect target.
  assign w_redirect_pc = redirect_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};

  // A response is thrown away if its fetch was squashed earlier (r_kill) or
  // is being squashed right now.
  assign w_drop_rsp = r_kill | redirect_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Redirects are ignored here; fetching starts from the reset PC.
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end

        S_REQ: begin
          // The address may still change while the request is unaccepted.
          if (redirect_i) begin
            r_pc <= w_redirect_pc;
          end
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            // Accepted for the old PC while redirecting: squash its response.
            r_kill      <= redirect_i;
          end
        end

        S_WAIT: begin
          if (redirect_i) begin
            r_pc <= w_redirect_pc;
          end
          if (imem_rsp_valid) begin
            r_kill <= 1'b0;
            if (w_drop_rsp) begin
              // PC already holds the redirect target: refetch from there.
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state      <= S_VALID;
              r_inst_valid <= 1'b1;
              r_inst       <= imem_rsp_data;
              r_inst_addr  <= r_pc;
            end
          end else if (redirect_i) begin
            r_kill <= 1'b1;
          end
        end

        S_VALID: begin
          // Redirect beats the sequential pc+4 and discards the held word.
          if (redirect_i) begin
            r_pc         <= w_redirect_pc;
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end else if (inst_ready_i) begin
            r_pc         <= r_pc + {{(XLEN-3){1'b0}}, 3'd4};
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_kill       <= 1'b0;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid_o   = r_inst_valid;
  assign inst_o         = r_inst;
  assign inst_addr_o    = r_inst_addr;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
module tb_ysyx_25060170_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  ysyx_25060170_ifu #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: where the fetch stream should be, in program terms.
  logic [31:0] exp_pc;      // architectural PC the IFU should be working on
  bit          started;     // one cycle has passed since reset release
  bit          pend;        // a request was accepted, response not yet returned
  bit          stale;       // that pending response belongs to a squashed PC
  bit          have_inst;   // decode should currently see a valid instruction
  logic [31:0] pend_addr;
  int          cnt;         // cycles until the pending response is returned
  int          lat;         // memory latency for the next accepted request
  int          hs_count;
  logic [31:0] last_hs_addr;
  int          n_assert;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    // multiplication by an odd constant is a bijection: distinct words per address
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    started   = 1'b0;
    pend      = 1'b0;
    stale     = 1'b0;
    have_inst = 1'b0;
    cnt       = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  // the model by what happens at the edge, then move to 1 time unit after it.
  task automatic tick(input bit rq, input bit ir, input bit rd, input logic [31:0] tgt,
                      input bit spurious);
    bit          rsp_now;
    bit          exp_req;
    bit          accept;
    bit          rd_eff;
    rd_eff         = rd && started;
    rsp_now        = pend && (cnt == 0);
    exp_req        = started && !pend && !have_inst;
    accept         = exp_req && rq;
    imem_req_ready = rq;
    inst_ready_i   = ir;
    redirect_i     = rd_eff;
    redirect_pc_i  = tgt;
    imem_rsp_valid = rsp_now || (spurious && !pend);
    imem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom;

    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", imem_addr, exp_pc);
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, have_inst});
    if (have_inst) begin
      chk("inst_addr", inst_addr_o, exp_pc);
      chk("inst_data", inst_o, mem_word(exp_pc));
    end

    if (rd_eff) begin
      exp_pc    = tgt & 32'hFFFF_FFFC;
      have_inst = 1'b0;
      if (pend) stale = !rsp_now;
      if (accept) stale = 1'b1;
    end else begin
      if (have_inst && ir) begin
        $display("handshake pc=%h inst=%h", inst_addr_o, inst_o);
        hs_count++;
        last_hs_addr = exp_pc;
        have_inst = 1'b0;
        exp_pc    = exp_pc + 32'd4;
      end
      if (rsp_now) begin
        if (stale) stale = 1'b0;
        else have_inst = 1'b1;
      end
    end
    if (rsp_now) pend = 1'b0;
    else if (pend) cnt--;
    if (accept) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = lat - 1;
    end

    @(posedge clk);
    #1;
    started = 1'b1;
  endtask

  task automatic wait_inst(input int max);
    for (int i = 0; i < max; i++) begin
      if (inst_valid_o) break;
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("timeout_inst", {31'b0, inst_valid_o}, 32'd1);
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max; i++) begin
      if (imem_req_valid) break;
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("timeout_req", {31'b0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    hs_count       = 0;
    last_hs_addr   = 32'h0;
    pend_addr      = 32'h0;
    lat            = 1;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'h0;
    inst_ready_i   = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_addr", inst_addr_o, 32'd0);
    rst = 1'b1;

    // 1: free-running fetch, one instruction every third cycle
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_hs_count", hs_count, 32'd3);
    chk("t1_last_addr", last_hs_addr, 32'h8000_0008);

    // 2: memory not ready for 4 cycles, request held
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // 3: decode stalls 5 cycles in VALID
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // 4: redirect while waiting, response arrives next cycle and is dropped
    lat = 2;
    wait_req(10);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_addr", imem_addr, 32'h8000_0100);
    lat = 1;

    // 5: unaligned redirect while an instruction is held
    wait_inst(10);
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0203, 1'b0);
    chk("t5_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("t5_addr", imem_addr, 32'h8000_0200);

    // 6a: PC wraps from FFFF_FFFC to 0
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_inst(10);
    chk("t6_inst_addr", inst_addr_o, 32'hFFFF_FFFC);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);

    // 6b: async reset while waiting on memory, orphan response afterwards
    lat = 2;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("t6_rst_inst", inst_o, 32'd0);
    chk("t6_rst_inst_addr", inst_addr_o, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    lat = 1;
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    wait_req(5);
    chk("t6_refetch_addr", imem_addr, RESET_PC);

    // Randomized traffic: stalls, latencies, redirects and stray responses
    for (int i = 0; i < 600; i++) begin
      bit          rq;
      bit          ir;
      bit          rd;
      logic [31:0] tgt;
      rq  = ($urandom_range(0, 99) < 70);
      ir  = ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 6);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (rd && have_inst) ir = 1'b0;
      lat = $urandom_range(1, 3);
      tick(rq, ir, rd, tgt, ($urandom_range(0, 99) < 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
